// File: rtl/bitmap_plot_reader.sv
// Walks the 1-bit bitmap BRAM and hands pixels to the plotter one at a time under its ready handshake.
// Define BITMAP_PLOT_SERPENTINE_EN for a boustrophedon scan; the default build scans in raster order.
module bitmap_plot_reader #(
   parameter int WIDTH        = 80,
   parameter int HEIGHT       = 106,
   parameter int ADDR_W       = 17,
   parameter int READ_LATENCY = 2
) (
   input  logic              clk_65mhz,
   input  logic              cpu_resetn,
   input  logic              start_in,
   input  logic              ready_next_pixel_in,
   output logic [ADDR_W-1:0] addr_out,
   input  logic              bram_data_in,
   output logic              pixel_value_out,
   output logic              pixel_valid_out,
   output logic [6:0]        row_out,
   output logic [6:0]        col_out,
   output logic              dir_out,
   output logic              busy_out,
   output logic              done_out
);

   // One cycle for addr_out to reach the BRAM, then READ_LATENCY cycles for doutb to settle.
   localparam int FETCH_CYCLES = READ_LATENCY + 1;
   localparam int CNT_W        = $clog2(FETCH_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] fetch_cnt;
   logic             at_row_end;
   logic             last_pos;

`ifdef BITMAP_PLOT_SERPENTINE_EN
   assign at_row_end = dir_out ? (col_out == 7'(WIDTH - 1)) : (col_out == 7'd0);
`else
   assign at_row_end = (col_out == 7'(WIDTH - 1));
`endif
   assign last_pos = at_row_end && (row_out == 7'(HEIGHT - 1));

   always_ff @(posedge clk_65mhz or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state           <= IDLE;
         fetch_cnt       <= '0;
         addr_out        <= '0;
         pixel_value_out <= 1'b0;
         pixel_valid_out <= 1'b0;
         row_out         <= '0;
         col_out         <= '0;
         dir_out         <= 1'b1;
         busy_out        <= 1'b0;
         done_out        <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  row_out   <= '0;
                  col_out   <= '0;
                  addr_out  <= '0;
                  dir_out   <= 1'b1;
                  fetch_cnt <= CNT_W'(FETCH_CYCLES);
                  busy_out  <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (fetch_cnt == '0) begin
                  pixel_value_out <= bram_data_in;
                  pixel_valid_out <= 1'b1;
                  state           <= PRESENT;
               end else begin
                  fetch_cnt <= fetch_cnt - 1'b1;
               end
            end
            PRESENT: begin
               if (ready_next_pixel_in) begin
                  pixel_valid_out <= 1'b0;
                  if (last_pos) begin
                     busy_out <= 1'b0;
                     state    <= DONE;
                  end else begin
                     fetch_cnt <= CNT_W'(FETCH_CYCLES);
                     state     <= FETCH;
`ifdef BITMAP_PLOT_SERPENTINE_EN
                     // Row change keeps the column, so the address jumps a full row.
                     if (at_row_end) begin
                        row_out  <= row_out + 7'd1;
                        dir_out  <= ~dir_out;
                        addr_out <= addr_out + ADDR_W'(WIDTH);
                     end else if (dir_out) begin
                        col_out  <= col_out + 7'd1;
                        addr_out <= addr_out + 1'b1;
                     end else begin
                        col_out  <= col_out - 7'd1;
                        addr_out <= addr_out - 1'b1;
                     end
`else
                     if (at_row_end) begin
                        row_out <= row_out + 7'd1;
                        col_out <= '0;
                     end else begin
                        col_out <= col_out + 7'd1;
                     end
                     addr_out <= addr_out + 1'b1;
`endif
                  end
               end
            end
            DONE: begin
               done_out <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitmap_plot_reader.sv
// Randomized bench for bitmap_plot_reader: small 4x3 image, 2-cycle BRAM model, scan order from a plain index model.
module tb_bitmap_plot_reader;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int AW = 4;
   localparam int RL = 2;
`ifdef BITMAP_PLOT_SERPENTINE_EN
   localparam bit SERP = 1'b1;
`else
   localparam bit SERP = 1'b0;
`endif

   logic          clk_65mhz = 1'b0;
   logic          cpu_resetn = 1'b0;
   logic          start_in = 1'b0;
   logic          ready_next_pixel_in = 1'b0;
   logic [AW-1:0] addr_out;
   logic          bram_data_in;
   logic          pixel_value_out, pixel_valid_out;
   logic [6:0]    row_out, col_out;
   logic          dir_out, busy_out, done_out;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   bit          mem [16];
   logic [RL-1:0] rd_pipe = '0;

   always #5 clk_65mhz = ~clk_65mhz;

   bitmap_plot_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LATENCY(RL)) dut (
      .clk_65mhz          (clk_65mhz),
      .cpu_resetn         (cpu_resetn),
      .start_in           (start_in),
      .ready_next_pixel_in(ready_next_pixel_in),
      .addr_out           (addr_out),
      .bram_data_in       (bram_data_in),
      .pixel_value_out    (pixel_value_out),
      .pixel_valid_out    (pixel_valid_out),
      .row_out            (row_out),
      .col_out            (col_out),
      .dir_out            (dir_out),
      .busy_out           (busy_out),
      .done_out           (done_out)
   );

   // BRAM read port with RL-cycle latency
   always @(posedge clk_65mhz) begin
      rd_pipe[0] <= mem[addr_out];
      for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bram_data_in = rd_pipe[RL-1];

   always @(posedge clk_65mhz) if (done_out === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"},  32'(addr_out), 0);
      chk({tag, "_val"},   32'(pixel_value_out), 0);
      chk({tag, "_vld"},   32'(pixel_valid_out), 0);
      chk({tag, "_row"},   32'(row_out), 0);
      chk({tag, "_col"},   32'(col_out), 0);
      chk({tag, "_dir"},   32'(dir_out), 1);
      chk({tag, "_busy"},  32'(busy_out), 0);
      chk({tag, "_done"},  32'(done_out), 0);
   endtask

   task automatic run_scan(input bit abort_mid, input bit long_hold);
      int r, c, a, d, lat, hold, done0;
      bit inj, unstable, held_val;
      for (int i = 0; i < 16; i++) mem[i] = 1'($urandom_range(0, 1));
      done0 = done_cnt;
      @(negedge clk_65mhz) start_in = 1'b1;
      @(negedge clk_65mhz) start_in = 1'b0;
      for (int idx = 0; idx < W * H; idx++) begin
         r = idx / W;
         c = (SERP && (r % 2 == 1)) ? (W - 1 - (idx % W)) : (idx % W);
         a = r * W + c;
         d = SERP ? ((r % 2 == 0) ? 1 : 0) : 1;
         // position is updated on the leaving edge, before the pixel is valid
         chk("pos_addr", 32'(addr_out), a);
         chk("pos_row",  32'(row_out), r);
         chk("pos_col",  32'(col_out), c);
         chk("pos_dir",  32'(dir_out), d);
         chk("fetch_busy", 32'(busy_out), 1);
         inj = (idx % 3 == 1);
         lat = 0;
         while (pixel_valid_out !== 1'b1 && lat < 50) begin
            @(negedge clk_65mhz);
            lat++;
            ready_next_pixel_in = inj && (lat == 1);
         end
         ready_next_pixel_in = 1'b0;
         chk("latency", lat, RL + 2);
         chk("pix_addr", 32'(addr_out), a);
         chk("pix_value", 32'(pixel_value_out), 32'(mem[a]));
         if (abort_mid && r == 1 && c == 2) begin
            #2 cpu_resetn = 1'b0;
            #1 chk_reset_vals("midrst");
            @(negedge clk_65mhz);
            @(negedge clk_65mhz);
            chk_reset_vals("midrst_hold");
            chk("midrst_nodone", done_cnt, done0);
            cpu_resetn = 1'b1;
            return;
         end
         hold = (long_hold && idx == 5) ? 1000 : int'($urandom_range(0, 3));
         held_val = pixel_value_out;
         unstable = 1'b0;
         for (int k = 0; k < hold; k++) begin
            start_in = 1'($urandom_range(0, 1));
            @(negedge clk_65mhz);
            if (pixel_valid_out !== 1'b1 || pixel_value_out !== held_val ||
                addr_out !== AW'(a)) unstable = 1'b1;
         end
         start_in = 1'b0;
         chk("hold_stable", 32'(unstable), 0);
         chk("hold_row", 32'(row_out), r);
         chk("hold_col", 32'(col_out), c);
         ready_next_pixel_in = 1'b1;
         @(negedge clk_65mhz) ready_next_pixel_in = 1'b0;
         chk("ready_drop_vld", 32'(pixel_valid_out), 0);
      end
      chk("end_busy", 32'(busy_out), 0);
      chk("end_done_early", 32'(done_out), 0);
      @(negedge clk_65mhz);
      chk("end_done", 32'(done_out), 1);
      @(negedge clk_65mhz);
      chk("end_done_clr", 32'(done_out), 0);
      chk("end_done_cnt", done_cnt, done0 + 1);
   endtask

   initial begin
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_65mhz);
         start_in = 1'($urandom_range(0, 1));
         ready_next_pixel_in = 1'($urandom_range(0, 1));
      end
      @(negedge clk_65mhz);
      chk_reset_vals("rst");
      start_in = 1'b0;
      ready_next_pixel_in = 1'b0;
      cpu_resetn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_65mhz);
         ready_next_pixel_in = (k == 2);
      end
      ready_next_pixel_in = 1'b0;
      @(negedge clk_65mhz);
      chk_reset_vals("idle");
      chk("idle_done_cnt", done_cnt, 0);

      run_scan(1'b0, 1'b1);
      run_scan(1'b1, 1'b0);
      repeat (3) @(negedge clk_65mhz);
      run_scan(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
